rt_deadline_monitor: RTL and testbench

Downstream observer for the bounded-counter synthesis bench. It consumes the bench's real-time check/event strobes and its error flag. It measures the gap, in event cycles, between successive checks and reports soft deadline misses. It escalates to a sticky hard error that the model checker and synthesis flow use as the safety property.

---
 rtl/rt_deadline_monitor_pkg.sv | 14 +
 rtl/rt_deadline_monitor_if.sv | 26 ++
 rtl/rt_deadline_monitor_sat_counter.sv | 43 ++++
 rtl/rt_deadline_monitor.sv | 115 +++++++++++
 tb/tb_rt_deadline_monitor.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/rt_deadline_monitor_pkg.sv
// Shared types and defaults for the real-time deadline monitor.
package rt_mon_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    HARD_ERR = 2'd2
  } rt_state_e;

  localparam int DEF_DEADLINE   = 20;
  localparam int DEF_MAX_MISSES = 3;
  localparam int MISS_W         = 3;

endpackage

// File: rtl/rt_deadline_monitor_if.sv
// Strobe inputs and status outputs of the deadline monitor.
interface rt_deadline_monitor_if #(
  parameter int CNT_W = 6
) ();

  logic             check_i;
  logic             event_i;
  logic             err_i;
  logic             clear_i;
  logic             armed_o;
  logic [CNT_W-1:0] gap_o;
  logic [2:0]       miss_cnt_o;
  logic             soft_miss_o;
  logic             error;

  modport master (
    output check_i, event_i, err_i, clear_i,
    input  armed_o, gap_o, miss_cnt_o, soft_miss_o, error
  );

  modport slave (
    input  check_i, event_i, err_i, clear_i,
    output armed_o, gap_o, miss_cnt_o, soft_miss_o, error
  );

endinterface

// File: rtl/rt_deadline_monitor_sat_counter.sv
// Clearable up-counter reaching LIMIT: either restarts at 0 (WRAP) or saturates at LIMIT.
// term_o flags the increment that reaches LIMIT, so the owner can register a pulse.
module rt_sat_counter #(
  parameter int W     = 6,
  parameter int LIMIT = 20,
  parameter bit WRAP  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    term_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (cnt_q == LAST) begin
        term_o = 1'b1;
        cnt_d  = WRAP ? '0 : TOP;
      end else if (WRAP || (cnt_q != TOP)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rt_deadline_monitor.sv
// Measures event-cycle gaps between checks, pulses on soft deadline misses and
// escalates to a sticky hard error after MAX_MISSES misses or any upstream error.
module rt_deadline_monitor
  import rt_mon_pkg::*;
#(
  parameter int DEADLINE   = DEF_DEADLINE,
  parameter int MAX_MISSES = DEF_MAX_MISSES,
  parameter int CNT_W      = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  rt_deadline_monitor_if.slave mon
);

  if ((2 ** CNT_W) <= DEADLINE || DEADLINE < 1) begin : g_bad_deadline
    $error("rt_deadline_monitor: CNT_W too narrow for DEADLINE");
  end
  if (MAX_MISSES < 1 || MAX_MISSES > 7) begin : g_bad_misses
    $error("rt_deadline_monitor: MAX_MISSES must be 1..7");
  end

  rt_state_e         state_q, state_d;
  logic              soft_miss_q, soft_miss_d;
  logic              armed_q, error_q;
  logic              gap_clr, gap_inc, gap_term;
  logic              miss_clr, miss_inc, miss_term;
  logic [CNT_W-1:0]  gap_cnt;
  logic [MISS_W-1:0] miss_cnt;

  rt_sat_counter #(.W(CNT_W), .LIMIT(DEADLINE), .WRAP(1'b1)) u_gap (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (gap_clr),
    .inc_i  (gap_inc),
    .cnt_o  (gap_cnt),
    .term_o (gap_term)
  );

  rt_sat_counter #(.W(MISS_W), .LIMIT(MAX_MISSES), .WRAP(1'b0)) u_miss (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (miss_clr),
    .inc_i  (miss_inc),
    .cnt_o  (miss_cnt),
    .term_o (miss_term)
  );

  // Priority: err_i, clear_i, check_i, event_i. An upstream error freezes the counters.
  always_comb begin
    state_d     = state_q;
    soft_miss_d = 1'b0;
    gap_clr     = 1'b0;
    gap_inc     = 1'b0;
    miss_clr    = 1'b0;
    miss_inc    = 1'b0;
    if (mon.err_i) begin
      state_d = HARD_ERR;
    end else begin
      case (state_q)
        IDLE: begin
          if (!mon.clear_i && mon.check_i) begin
            state_d  = TRACK;
            gap_clr  = 1'b1;
            miss_clr = 1'b1;
          end
        end
        TRACK: begin
          if (mon.clear_i) begin
            state_d  = IDLE;
            gap_clr  = 1'b1;
            miss_clr = 1'b1;
          end else if (mon.check_i) begin
            gap_clr = 1'b1;
          end else if (mon.event_i) begin
            gap_inc = 1'b1;
            if (gap_term) begin
              soft_miss_d = 1'b1;
              miss_inc    = 1'b1;
              if (miss_term) state_d = HARD_ERR;
            end
          end
        end
        HARD_ERR: begin
          if (mon.clear_i) begin
            state_d  = IDLE;
            gap_clr  = 1'b1;
            miss_clr = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      soft_miss_q <= 1'b0;
      armed_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      soft_miss_q <= soft_miss_d;
      armed_q     <= (state_d == TRACK);
      error_q     <= (state_d == HARD_ERR);
    end
  end

  assign mon.armed_o     = armed_q;
  assign mon.error       = error_q;
  assign mon.soft_miss_o = soft_miss_q;
  assign mon.gap_o       = gap_cnt;
  assign mon.miss_cnt_o  = miss_cnt;

endmodule

// File: tb/tb_rt_deadline_monitor.sv
// Bench for rt_deadline_monitor: vector table, directed corner sequences and
// random strobes against an arithmetic reference model.
module tb_rt_deadline_monitor;

  localparam int DEADLINE   = 20;
  localparam int MAX_MISSES = 3;
  localparam int CNT_W      = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rt_deadline_monitor_if #(.CNT_W(CNT_W)) mif ();

  rt_deadline_monitor #(
    .DEADLINE(DEADLINE), .MAX_MISSES(MAX_MISSES), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain flags and integer counters.
  bit m_armed, m_hard, m_pulse;
  int m_gap, m_miss;

  typedef struct {
    bit c, e, er, cl;
    bit a;
    int g;
    int m;
    bit s;
    bit x;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_hard = 0; m_pulse = 0; m_gap = 0; m_miss = 0;
  endtask

  task automatic model_step(input bit c, input bit e, input bit er, input bit cl);
    m_pulse = 0;
    if (er) begin
      m_hard = 1; m_armed = 0;
    end else if (m_hard) begin
      if (cl) begin m_hard = 0; m_gap = 0; m_miss = 0; end
    end else if (m_armed) begin
      if (cl) begin
        m_armed = 0; m_gap = 0; m_miss = 0;
      end else if (c) begin
        m_gap = 0;
      end else if (e) begin
        m_gap++;
        if (m_gap == DEADLINE) begin
          m_gap = 0;
          m_pulse = 1;
          if (m_miss < MAX_MISSES) m_miss++;
          if (m_miss == MAX_MISSES) begin m_hard = 1; m_armed = 0; end
        end
      end
    end else if (!cl && c) begin
      m_armed = 1; m_gap = 0; m_miss = 0;
    end
  endtask

  task automatic cycle(input bit c, input bit e, input bit er, input bit cl);
    mif.check_i = c; mif.event_i = e; mif.err_i = er; mif.clear_i = cl;
    @(posedge clk);
    #1;
    model_step(c, e, er, cl);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".armed"}, int'(mif.armed_o), int'(m_armed));
    chk({tag, ".gap"}, int'(mif.gap_o), m_gap);
    chk({tag, ".miss"}, int'(mif.miss_cnt_o), m_miss);
    chk({tag, ".soft"}, int'(mif.soft_miss_o), int'(m_pulse));
    chk({tag, ".error"}, int'(mif.error), int'(m_hard));
  endtask

  task automatic cmp_zero(input string tag);
    chk({tag, ".armed"}, int'(mif.armed_o), 0);
    chk({tag, ".gap"}, int'(mif.gap_o), 0);
    chk({tag, ".miss"}, int'(mif.miss_cnt_o), 0);
    chk({tag, ".soft"}, int'(mif.soft_miss_o), 0);
    chk({tag, ".error"}, int'(mif.error), 0);
  endtask

  initial begin
    int peak, pulses, first_pulse, err_rise;

    vecs[0]  = '{0,1,0,0, 0, 0,0,0,0};
    vecs[1]  = '{0,0,0,0, 0, 0,0,0,0};
    vecs[2]  = '{1,0,0,0, 1, 0,0,0,0};
    vecs[3]  = '{0,1,0,0, 1, 1,0,0,0};
    vecs[4]  = '{0,1,0,0, 1, 2,0,0,0};
    vecs[5]  = '{1,1,0,0, 1, 0,0,0,0};
    vecs[6]  = '{0,1,0,0, 1, 1,0,0,0};
    vecs[7]  = '{0,0,0,0, 1, 1,0,0,0};
    vecs[8]  = '{0,0,0,1, 0, 0,0,0,0};
    vecs[9]  = '{0,1,0,0, 0, 0,0,0,0};
    vecs[10] = '{1,0,0,0, 1, 0,0,0,0};
    vecs[11] = '{0,1,0,0, 1, 1,0,0,0};
    vecs[12] = '{0,0,1,0, 0, 1,0,0,1};
    vecs[13] = '{0,0,1,1, 0, 1,0,0,1};
    vecs[14] = '{0,0,0,1, 0, 0,0,0,0};
    vecs[15] = '{0,1,0,0, 0, 0,0,0,0};
    vecs[16] = '{0,0,1,1, 0, 0,0,0,1};
    vecs[17] = '{0,0,0,1, 0, 0,0,0,0};
    vecs[18] = '{1,0,0,1, 0, 0,0,0,0};

    rst_n = 1'b0;
    mif.check_i = 0; mif.event_i = 0; mif.err_i = 0; mif.clear_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 0);
      cmp_model("idle_events");
    end

    for (int i = 0; i < 19; i++) begin
      cycle(vecs[i].c, vecs[i].e, vecs[i].er, vecs[i].cl);
      chk($sformatf("vec%0d.armed", i), int'(mif.armed_o), int'(vecs[i].a));
      chk($sformatf("vec%0d.gap", i), int'(mif.gap_o), vecs[i].g);
      chk($sformatf("vec%0d.miss", i), int'(mif.miss_cnt_o), vecs[i].m);
      chk($sformatf("vec%0d.soft", i), int'(mif.soft_miss_o), int'(vecs[i].s));
      chk($sformatf("vec%0d.error", i), int'(mif.error), int'(vecs[i].x));
    end

    // Upstream counter reset at 15: never misses.
    cycle(0, 0, 0, 1);
    peak = 0; pulses = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(i % 16 == 0, i % 16 != 0, 0, 0);
      cmp_model("period16");
      if (int'(mif.gap_o) > peak) peak = int'(mif.gap_o);
      if (mif.soft_miss_o) pulses++;
    end
    chk("period16.peak", peak, 15);
    chk("period16.pulses", pulses, 0);
    chk("period16.armed", int'(mif.armed_o), 1);

    // Free-running upstream: 31 events between checks.
    cycle(0, 0, 0, 1);
    first_pulse = -1; err_rise = -1;
    for (int i = 0; i < 100; i++) begin
      cycle(i % 32 == 0, i % 32 != 0, 0, 0);
      cmp_model("free32");
      if (mif.soft_miss_o && first_pulse < 0) begin
        first_pulse = i;
        chk("free32.gap_after_miss", int'(mif.gap_o), 0);
      end
      if (mif.error && err_rise < 0) begin
        err_rise = i;
        chk("free32.miss_at_err", int'(mif.miss_cnt_o), 3);
        chk("free32.soft_at_err", int'(mif.soft_miss_o), 1);
      end
    end
    chk("free32.first_pulse", first_pulse, 20);
    chk("free32.err_rise", err_rise, 84);
    chk("free32.err_sticky", int'(mif.error), 1);

    cycle(0, 0, 1, 1);
    chk("herr.clear_with_err", int'(mif.error), 1);
    cycle(0, 0, 0, 1);
    cmp_zero("herr.clear");

    // Check and event together at gap 19.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 19; i++) cycle(0, 1, 0, 0);
    chk("ce.gap19", int'(mif.gap_o), 19);
    cycle(1, 1, 0, 0);
    cmp_model("ce.both");
    chk("ce.gap", int'(mif.gap_o), 0);
    chk("ce.soft", int'(mif.soft_miss_o), 0);
    chk("ce.miss", int'(mif.miss_cnt_o), 0);

    // Asynchronous reset mid-cycle with gap 12 and two misses.
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 52; i++) cycle(0, 1, 0, 0);
    chk("areset.pre_gap", int'(mif.gap_o), 12);
    chk("areset.pre_miss", int'(mif.miss_cnt_o), 2);
    #2;
    rst_n = 1'b0;
    #1;
    cmp_zero("areset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0, 0);
    cmp_model("areset.rearm");
    chk("areset.armed", int'(mif.armed_o), 1);

    // Random strobes against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0);
      cmp_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
